// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the RPN stack/ALU sequencer.
//   estado_t        : sequencer FSM states
//   OP_*            : keypad opcodes understood by the ALU (A..E)
//   ERR_*           : error codes reported to the display stage
//   es_opcode_valido: true for opcodes in the A..E range
package secuenciador_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      ESCRIBIR_NUM = 3'd1,
      LEER_OPS     = 3'd2,
      ESPERAR_ALU  = 3'd3,
      ESCRIBIR_RES = 3'd4
   } estado_t;

   localparam logic [3:0] OP_SUMA  = 4'hA;
   localparam logic [3:0] OP_RESTA = 4'hB;
   localparam logic [3:0] OP_MULT  = 4'hC;
   localparam logic [3:0] OP_DIV   = 4'hD;
   localparam logic [3:0] OP_MOD   = 4'hE;

   localparam logic [2:0] ERR_NINGUNO        = 3'b000;
   localparam logic [2:0] ERR_FALTA_OPERANDO = 3'b001;
   localparam logic [2:0] ERR_PILA_LLENA     = 3'b010;
   localparam logic [2:0] ERR_OPCODE         = 3'b011;
   localparam logic [2:0] ERR_DIVCERO        = 3'b100;

   function automatic logic es_opcode_valido(input logic [3:0] op);
      return (op >= OP_SUMA) && (op <= OP_MOD);
   endfunction

endpackage

// File: rtl/secuenciador_pila_alu.sv
// RPN operand-stack sequencer for the keypad calculator. Accepts numbers and
// operations over valid/ready, owns the single RF write port, drives the RF
// read addresses and ALU operands, and tracks stack depth and error codes.
// Operand i lives at RF address i+1; address 0 is never written.
//
// Ports:
//   clk, reset_pi                  clock, async active-high reset
//   num_valid_pi/num_dato_pi/num_ready_o   keypad number handshake
//   op_valid_pi/op_codigo_pi/op_ready_o    operation handshake (op wins ties)
//   rf_we_o/rf_waddr_o/rf_wdata_o  RF write port
//   rf_raddr1_o/rf_raddr2_o, rf_rdata1_pi/rf_rdata2_pi   RF async read ports
//   alu_op_o/alu_a_o/alu_b_o, alu_res_pi   ALU interface
//   resultado_valid_o/resultado_o  result pulse and last written result
//   cuenta_o                       stack depth
//   codigo_error_o                 last error code (000 = none)
//
// Build option: SECUENCIADOR_DIVCERO_EN suppresses the result write of a
// D/E operation whose divisor is zero and reports error 100 instead.
module secuenciador_pila_alu
   import secuenciador_pkg::*;
#(
   parameter int unsigned ANCHO_DATO = 16,
   parameter int unsigned ANCHO_DIR  = 5,
   parameter int unsigned LAT_ALU    = 1
) (
   input  logic                  clk,
   input  logic                  reset_pi,
   input  logic                  num_valid_pi,
   input  logic [ANCHO_DATO-1:0] num_dato_pi,
   output logic                  num_ready_o,
   input  logic                  op_valid_pi,
   input  logic [3:0]            op_codigo_pi,
   output logic                  op_ready_o,
   output logic                  rf_we_o,
   output logic [ANCHO_DIR-1:0]  rf_waddr_o,
   output logic [ANCHO_DATO-1:0] rf_wdata_o,
   output logic [ANCHO_DIR-1:0]  rf_raddr1_o,
   output logic [ANCHO_DIR-1:0]  rf_raddr2_o,
   input  logic [ANCHO_DATO-1:0] rf_rdata1_pi,
   input  logic [ANCHO_DATO-1:0] rf_rdata2_pi,
   output logic [3:0]            alu_op_o,
   output logic [ANCHO_DATO-1:0] alu_a_o,
   output logic [ANCHO_DATO-1:0] alu_b_o,
   input  logic [ANCHO_DATO-1:0] alu_res_pi,
   output logic                  resultado_valid_o,
   output logic [ANCHO_DATO-1:0] resultado_o,
   output logic [ANCHO_DIR-1:0]  cuenta_o,
   output logic [2:0]            codigo_error_o
);

   localparam int unsigned ANCHO_CNT = (LAT_ALU > 1) ? $clog2(LAT_ALU) : 1;
   localparam logic [ANCHO_DIR-1:0] CUENTA_MAX = '1;

   estado_t                estado;
   logic [ANCHO_DIR-1:0]   cuenta;
   logic [ANCHO_CNT-1:0]   cnt_espera;
   logic [ANCHO_DATO-1:0]  wdata_q;
   logic [ANCHO_DATO-1:0]  resultado_q;
   logic                   div_cero;

   // Ready depends on the live op request so an operation wins a tie.
   assign op_ready_o  = (estado == IDLE) && !reset_pi;
   assign num_ready_o = op_ready_o && !op_valid_pi;
   assign cuenta_o    = cuenta;

   // The ALU result is only guaranteed in ESCRIBIR_RES, so it is forwarded
   // straight to the write port and result output during that cycle.
   assign rf_wdata_o  = (estado == ESCRIBIR_RES) ? alu_res_pi : wdata_q;
   assign resultado_o = resultado_valid_o ? alu_res_pi : resultado_q;

`ifdef SECUENCIADOR_DIVCERO_EN
   assign div_cero = ((alu_op_o == OP_DIV) || (alu_op_o == OP_MOD)) &&
                     (alu_b_o == '0);
`else
   assign div_cero = 1'b0;
`endif

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge reset_pi) begin
      if (reset_pi) begin
         estado            <= IDLE;
         cuenta            <= '0;
         cnt_espera        <= '0;
         wdata_q           <= '0;
         resultado_q       <= '0;
         rf_we_o           <= 1'b0;
         rf_waddr_o        <= '0;
         rf_raddr1_o       <= '0;
         rf_raddr2_o       <= '0;
         alu_op_o          <= '0;
         alu_a_o           <= '0;
         alu_b_o           <= '0;
         resultado_valid_o <= 1'b0;
         codigo_error_o    <= ERR_NINGUNO;
      end else begin
         case (estado)
            IDLE: begin
               if (op_valid_pi) begin
                  if (cuenta < ANCHO_DIR'(2)) begin
                     codigo_error_o <= ERR_FALTA_OPERANDO;
                  end else if (!es_opcode_valido(op_codigo_pi)) begin
                     codigo_error_o <= ERR_OPCODE;
                  end else begin
                     codigo_error_o <= ERR_NINGUNO;
                     rf_raddr1_o    <= cuenta - ANCHO_DIR'(1);
                     rf_raddr2_o    <= cuenta;
                     alu_op_o       <= op_codigo_pi;
                     estado         <= LEER_OPS;
                  end
               end else if (num_valid_pi) begin
                  if (cuenta == CUENTA_MAX) begin
                     codigo_error_o <= ERR_PILA_LLENA;
                  end else begin
                     codigo_error_o <= ERR_NINGUNO;
                     rf_we_o        <= 1'b1;
                     rf_waddr_o     <= cuenta + ANCHO_DIR'(1);
                     wdata_q        <= num_dato_pi;
                     estado         <= ESCRIBIR_NUM;
                  end
               end
            end

            ESCRIBIR_NUM: begin
               rf_we_o    <= 1'b0;
               rf_waddr_o <= '0;
               wdata_q    <= '0;
               cuenta     <= cuenta + ANCHO_DIR'(1);
               estado     <= IDLE;
            end

            LEER_OPS: begin
               alu_a_o     <= rf_rdata1_pi;
               alu_b_o     <= rf_rdata2_pi;
               rf_raddr1_o <= '0;
               rf_raddr2_o <= '0;
               cnt_espera  <= ANCHO_CNT'(LAT_ALU - 1);
               estado      <= ESPERAR_ALU;
            end

            // Operands stay stable for LAT_ALU cycles.
            ESPERAR_ALU: begin
               if (cnt_espera == '0) begin
                  rf_we_o           <= !div_cero;
                  resultado_valid_o <= !div_cero;
                  rf_waddr_o        <= cuenta - ANCHO_DIR'(1);
                  estado            <= ESCRIBIR_RES;
               end else begin
                  cnt_espera <= cnt_espera - ANCHO_CNT'(1);
               end
            end

            // Two operands collapse into one; a suppressed write keeps depth.
            ESCRIBIR_RES: begin
               if (resultado_valid_o) begin
                  cuenta      <= cuenta - ANCHO_DIR'(1);
                  resultado_q <= alu_res_pi;
               end else begin
                  codigo_error_o <= ERR_DIVCERO;
               end
               rf_we_o           <= 1'b0;
               resultado_valid_o <= 1'b0;
               rf_waddr_o        <= '0;
               alu_op_o          <= '0;
               alu_a_o           <= '0;
               alu_b_o           <= '0;
               estado            <= IDLE;
            end

            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_secuenciador_pila_alu.sv
// Self-checking bench for secuenciador_pila_alu: table of directed
// transactions, hand-written corner sequences, then random traffic checked
// against a stack model held in a queue.
module tb_secuenciador_pila_alu;

   localparam int unsigned AD  = 16;
   localparam int unsigned AW  = 5;
   localparam int unsigned LAT = 1;

   logic          clk = 1'b0;
   logic          reset_pi;
   logic          num_valid_pi;
   logic [AD-1:0] num_dato_pi;
   logic          num_ready_o;
   logic          op_valid_pi;
   logic [3:0]    op_codigo_pi;
   logic          op_ready_o;
   logic          rf_we_o;
   logic [AW-1:0] rf_waddr_o;
   logic [AD-1:0] rf_wdata_o;
   logic [AW-1:0] rf_raddr1_o, rf_raddr2_o;
   logic [AD-1:0] rf_rdata1_pi, rf_rdata2_pi;
   logic [3:0]    alu_op_o;
   logic [AD-1:0] alu_a_o, alu_b_o, alu_res_pi;
   logic          resultado_valid_o;
   logic [AD-1:0] resultado_o;
   logic [AW-1:0] cuenta_o;
   logic [2:0]    codigo_error_o;

   always #5 clk = ~clk;

   secuenciador_pila_alu #(.ANCHO_DATO(AD), .ANCHO_DIR(AW), .LAT_ALU(LAT)) dut (
      .clk(clk), .reset_pi(reset_pi),
      .num_valid_pi(num_valid_pi), .num_dato_pi(num_dato_pi), .num_ready_o(num_ready_o),
      .op_valid_pi(op_valid_pi), .op_codigo_pi(op_codigo_pi), .op_ready_o(op_ready_o),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
      .rf_rdata1_pi(rf_rdata1_pi), .rf_rdata2_pi(rf_rdata2_pi),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_res_pi(alu_res_pi),
      .resultado_valid_o(resultado_valid_o), .resultado_o(resultado_o),
      .cuenta_o(cuenta_o), .codigo_error_o(codigo_error_o)
   );

   // Behavioural ALU (combinational, so LAT_ALU=1 is honoured trivially)
   function automatic logic [AD-1:0] alu_ref(input logic [3:0] op,
                                             input logic [AD-1:0] a, input logic [AD-1:0] b);
      logic [31:0] p;
      case (op)
         4'hA: return a + b;
         4'hB: return a - b;
         4'hC: begin p = 32'(a) * 32'(b); return p[AD-1:0]; end
         4'hD: return (b == '0) ? '1 : a / b;
         4'hE: return (b == '0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   assign alu_res_pi = alu_ref(alu_op_o, alu_a_o, alu_b_o);

   // Register file model
   logic [AD-1:0] rf_mem [0:31];
   assign rf_rdata1_pi = rf_mem[rf_raddr1_o];
   assign rf_rdata2_pi = rf_mem[rf_raddr2_o];
   always @(posedge clk) if (rf_we_o) rf_mem[rf_waddr_o] <= rf_wdata_o;

   // Write / result-pulse monitor
   typedef struct packed { logic [AW-1:0] addr; logic [AD-1:0] data; } wr_t;
   wr_t act_wq[$];
   wr_t exp_wq[$];
   int  act_pulses = 0;
   int  exp_pulses = 0;
   int  wr_idx = 0;

   always @(negedge clk) begin
      if (rf_we_o) act_wq.push_back('{rf_waddr_o, rf_wdata_o});
      if (resultado_valid_o) act_pulses++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the operand stack as a queue
   logic [AD-1:0] stk[$];
   logic [2:0]    m_err = 3'b000;
   logic [AD-1:0] m_res = '0;

   task automatic model_push(input logic [AD-1:0] d);
      if (stk.size() == 31) m_err = 3'b010;
      else begin
         stk.push_back(d);
         exp_wq.push_back('{AW'(stk.size()), d});
         m_err = 3'b000;
      end
   endtask

   task automatic model_op(input logic [3:0] code);
      logic [AD-1:0] a, b, r;
      if (stk.size() < 2) m_err = 3'b001;
      else if (code < 4'hA || code > 4'hE) m_err = 3'b011;
      else begin
         a = stk[stk.size()-2];
         b = stk[stk.size()-1];
         r = alu_ref(code, a, b);
`ifdef SECUENCIADOR_DIVCERO_EN
         if ((code == 4'hD || code == 4'hE) && b == '0) begin
            m_err = 3'b100;
            return;
         end
`endif
         void'(stk.pop_back());
         void'(stk.pop_back());
         stk.push_back(r);
         exp_wq.push_back('{AW'(stk.size()), r});
         exp_pulses++;
         m_res = r;
         m_err = 3'b000;
      end
   endtask

   task automatic model_reset();
      stk.delete();
      m_err = 3'b000;
      m_res = '0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".cuenta"}, 32'(cuenta_o), 32'(stk.size()));
      check({tag, ".error"}, 32'(codigo_error_o), 32'(m_err));
      check({tag, ".nwrites"}, 32'(act_wq.size()), 32'(exp_wq.size()));
      check({tag, ".pulses"}, 32'(act_pulses), 32'(exp_pulses));
      check({tag, ".resultado"}, 32'(resultado_o), 32'(m_res));
      while (wr_idx < act_wq.size() && wr_idx < exp_wq.size()) begin
         check({tag, ".write"}, 32'(act_wq[wr_idx]), 32'(exp_wq[wr_idx]));
         wr_idx++;
      end
      wr_idx = (act_wq.size() > exp_wq.size()) ? act_wq.size() : exp_wq.size();
   endtask

   // Waits (bounded) until the sequencer is back in IDLE; ends on a negedge
   task automatic wait_idle(input string tag);
      @(negedge clk);
      for (int n = 0; n < 20 && op_ready_o !== 1'b1; n++) @(negedge clk);
      check({tag, ".idle"}, 32'(op_ready_o), 32'd1);
   endtask

   // One transaction, started at a negedge with the DUT in IDLE
   task automatic send(input string tag, input bit is_op, input logic [AD-1:0] d,
                       input logic [3:0] code);
      if (is_op) begin op_valid_pi = 1'b1; op_codigo_pi = code; end
      else       begin num_valid_pi = 1'b1; num_dato_pi = d; end
      #1;
      check({tag, ".ready"}, 32'(is_op ? op_ready_o : num_ready_o), 32'd1);
      @(posedge clk);
      #1;
      op_valid_pi  = 1'b0;
      num_valid_pi = 1'b0;
      if (is_op) model_op(code); else model_push(d);
      wait_idle(tag);
   endtask

   typedef struct {
      bit            is_op;
      logic [AD-1:0] d;
      logic [3:0]    code;
      logic [2:0]    e_err;
      logic [AW-1:0] e_cnt;
      bit            e_wr;
      logic [AW-1:0] e_addr;
      logic [AD-1:0] e_data;
   } vec_t;

   vec_t tabla [10];

   initial begin
      int n_prev, lat_n;
      bit is_op;
      logic [3:0] code;
      logic [AD-1:0] d;

      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      tabla[0] = '{0, 16'd5,  4'h0, 3'b000, 5'd1, 1, 5'd1, 16'd5};
      tabla[1] = '{0, 16'd7,  4'h0, 3'b000, 5'd2, 1, 5'd2, 16'd7};
      tabla[2] = '{1, 16'd0,  4'hB, 3'b000, 5'd1, 1, 5'd1, 16'hFFFE};
      tabla[3] = '{1, 16'd0,  4'hA, 3'b001, 5'd1, 0, 5'd0, 16'd0};
      tabla[4] = '{0, 16'd3,  4'h0, 3'b000, 5'd2, 1, 5'd2, 16'd3};
      tabla[5] = '{1, 16'd0,  4'hF, 3'b011, 5'd2, 0, 5'd0, 16'd0};
      tabla[6] = '{1, 16'd0,  4'h0, 3'b011, 5'd2, 0, 5'd0, 16'd0};
      tabla[7] = '{1, 16'd0,  4'hC, 3'b000, 5'd1, 1, 5'd1, 16'hFFFA};
      tabla[8] = '{0, 16'd9,  4'h0, 3'b000, 5'd2, 1, 5'd2, 16'd9};
      tabla[9] = '{1, 16'd0,  4'hE, 3'b000, 5'd1, 1, 5'd1, 16'd1};

      reset_pi = 1'b1; num_valid_pi = 1'b0; op_valid_pi = 1'b0;
      num_dato_pi = '0; op_codigo_pi = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.we", 32'(rf_we_o), 0);
      check("rst.cuenta", 32'(cuenta_o), 0);
      check("rst.alu_a", 32'(alu_a_o), 0);
      check("rst.op_ready", 32'(op_ready_o), 0);
      reset_pi = 1'b0;
      #1;
      check("rst.op_ready_rel", 32'(op_ready_o), 1);
      check("rst.num_ready_rel", 32'(num_ready_o), 1);
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         n_prev = act_wq.size();
         send($sformatf("tab%0d", i), tabla[i].is_op, tabla[i].d, tabla[i].code);
         check($sformatf("tab%0d.err", i), 32'(codigo_error_o), 32'(tabla[i].e_err));
         check($sformatf("tab%0d.cnt", i), 32'(cuenta_o), 32'(tabla[i].e_cnt));
         check($sformatf("tab%0d.nwr", i), 32'(act_wq.size() - n_prev), 32'(tabla[i].e_wr));
         if (tabla[i].e_wr && act_wq.size() > n_prev)
            check($sformatf("tab%0d.wr", i), 32'(act_wq[n_prev]),
                  32'({tabla[i].e_addr, tabla[i].e_data}));
         check_state($sformatf("tab%0d", i));
      end

      // Fill to full, then one more push
      for (int i = 0; i < 30; i++) send("fill", 0, 16'($urandom), 4'h0);
      check_state("fill");
      check("full.cnt31", 32'(cuenta_o), 31);
      send("full", 0, 16'h55AA, 4'h0);
      check("full.err", 32'(codigo_error_o), 32'b010);
      check("full.cnt", 32'(cuenta_o), 31);
      check_state("full");

      // Simultaneous op and number: the op wins
      op_valid_pi = 1'b1; op_codigo_pi = 4'hA;
      num_valid_pi = 1'b1; num_dato_pi = 16'h1234;
      #1;
      check("tie.num_ready", 32'(num_ready_o), 0);
      check("tie.op_ready", 32'(op_ready_o), 1);
      @(posedge clk);
      #1;
      op_valid_pi = 1'b0;
      model_op(4'hA);
      lat_n = 0;
      @(negedge clk);
      while (num_ready_o !== 1'b1 && lat_n < 20) begin @(negedge clk); lat_n++; end
      check("tie.num_wait", 32'(lat_n < 20), 1);
      @(posedge clk);
      #1;
      num_valid_pi = 1'b0;
      model_push(16'h1234);
      wait_idle("tie");
      check_state("tie");

      // Latency and read addresses of op B at depth 2
      reset_pi = 1'b1; #1; reset_pi = 1'b0;
      model_reset();
      @(negedge clk);
      send("lat.p5", 0, 16'd5, 4'h0);
      send("lat.p7", 0, 16'd7, 4'h0);
      op_valid_pi = 1'b1; op_codigo_pi = 4'hB;
      @(posedge clk);
      #1;
      op_valid_pi = 1'b0;
      model_op(4'hB);
      lat_n = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check("lat.raddr1", 32'(rf_raddr1_o), 1);
            check("lat.raddr2", 32'(rf_raddr2_o), 2);
         end
         if (rf_we_o && lat_n == 0) lat_n = n;
         if (op_ready_o) break;
      end
      check("lat.cycles", 32'(lat_n), 32'(LAT + 2));
      check_state("lat");
      check("lat.cnt", 32'(cuenta_o), 1);

      // Async reset in the middle of ESPERAR_ALU
      send("ar.p4", 0, 16'd4, 4'h0);
      send("ar.p6", 0, 16'd6, 4'h0);
      op_valid_pi = 1'b1; op_codigo_pi = 4'hA;
      @(posedge clk);
      #1;
      op_valid_pi = 1'b0;
      n_prev = act_wq.size();
      @(negedge clk);
      @(negedge clk);
      #2;
      reset_pi = 1'b1;
      #1;
      check("ar.we", 32'(rf_we_o), 0);
      check("ar.cuenta", 32'(cuenta_o), 0);
      check("ar.alu_a", 32'(alu_a_o), 0);
      check("ar.alu_op", 32'(alu_op_o), 0);
      check("ar.op_ready", 32'(op_ready_o), 0);
      @(negedge clk);
      reset_pi = 1'b0;
      check("ar.nowrite", 32'(act_wq.size()), 32'(n_prev));
      model_reset();
      @(negedge clk);
      check_state("ar");

`ifdef SECUENCIADOR_DIVCERO_EN
      send("dz.p8", 0, 16'd8, 4'h0);
      send("dz.p0", 0, 16'd0, 4'h0);
      n_prev = act_wq.size();
      send("dz.opD", 1, 16'd0, 4'hD);
      check("dz.err", 32'(codigo_error_o), 32'b100);
      check("dz.nowrite", 32'(act_wq.size()), 32'(n_prev));
      check("dz.cnt", 32'(cuenta_o), 2);
      check_state("dz");
`endif

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         is_op = ($urandom_range(0, 2) == 0);
         code  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(4'hA + $urandom_range(0, 4));
         d     = ($urandom_range(0, 4) == 0) ? '0 : 16'($urandom);
         send("rnd", is_op, d, code);
         check_state("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/secuenciador_pila_alu.md
Name: secuenciador_pila_alu

Overview:
- Controller that sequences the shared register file and ALU for the keypad calculator, operating as an RPN-style operand stack.
- Accepts "number ready" and "operation ready" requests from the keypad front end over valid/ready handshakes.
- Arbitrates the single register-file write port between keypad numbers and ALU results.
- Drives RF read addresses and ALU operands/opcode, and tracks the stack depth and error codes for the display stage.

Parameters:
- ANCHO_DATO, 16, data width of RF entries and ALU operands/result.
- ANCHO_DIR, 5, RF address width; address 0 is reserved and never written.
- LAT_ALU, 1, ALU result latency in cycles (≥1) after operands/opcode are stable.

Ports:
- clk  in  1  system clock, rising edge.
- reset_pi  in  1  asynchronous, active-high reset.
- num_valid_pi  in  1  keypad number available.
- num_dato_pi  in  ANCHO_DATO  number value.
- num_ready_o  out  1  number handshake ready.
- op_valid_pi  in  1  operation request.
- op_codigo_pi  in  4  opcode: A=suma, B=resta, C=mult, D=div, E=modulo.
- op_ready_o  out  1  operation handshake ready.
- rf_we_o  out  1  RF write enable.
- rf_waddr_o  out  ANCHO_DIR  RF write address.
- rf_wdata_o  out  ANCHO_DATO  RF write data.
- rf_raddr1_o, rf_raddr2_o  out  ANCHO_DIR  RF read addresses (asynchronous read).
- rf_rdata1_pi, rf_rdata2_pi  in  ANCHO_DATO  RF read data, same-cycle.
- alu_op_o  out  4  ALU opcode.
- alu_a_o, alu_b_o  out  ANCHO_DATO  ALU operands.
- alu_res_pi  in  ANCHO_DATO  ALU result.
- resultado_valid_o  out  1  one-cycle pulse when a result is written.
- resultado_o  out  ANCHO_DATO  last written result, held until the next result.
- cuenta_o  out  ANCHO_DIR  stack depth.
- codigo_error_o  out  3  last error code, 000 = none.

Behaviour:
- Reset (async, reset_pi=1):
  - State goes to IDLE; cuenta = 0.
  - All outputs are 0, except num_ready_o and op_ready_o, which follow IDLE rules once reset is released.
  - Any write in progress is aborted; no rf_we_o pulse is produced.
- Stack layout: operand i is stored at address i+1. Depth cuenta ranges 0..2**ANCHO_DIR-1.
- Ready and transfer rules:
  - op_ready_o = (state==IDLE).
  - num_ready_o = (state==IDLE) && !op_valid_pi, so an operation wins a simultaneous request.
  - A transfer occurs when valid&&ready at a rising edge.
- States: IDLE, ESCRIBIR_NUM, LEER_OPS, ESPERAR_ALU, ESCRIBIR_RES.
- Number accepted at edge T (requires cuenta < 2**ANCHO_DIR-1):
  - Number is registered; state goes to ESCRIBIR_NUM for cycle T+1.
  - In ESCRIBIR_NUM: rf_we_o=1, waddr=cuenta+1, wdata=number. At the end of the cycle cuenta++ and the state returns to IDLE.
- Operation accepted (requires cuenta ≥ 2 and opcode in A..E):
  - LEER_OPS (1 cycle): raddr1=cuenta-1, raddr2=cuenta. rdata1/rdata2 are captured into the A/B registers, and alu_op_o is registered.
  - ESPERAR_ALU: lasts LAT_ALU cycles; alu_a_o, alu_b_o, alu_op_o are held stable. Counted by an internal counter.
  - ESCRIBIR_RES (1 cycle): rf_we_o=1, waddr=cuenta-1, wdata=alu_res_pi, resultado_valid_o=1, resultado_o updated. At the end of the cycle cuenta-- and the state returns to IDLE.
  - Latency from acceptance to result write is LAT_ALU+2 cycles.
- Errors: the handshake still completes, no RF write occurs, cuenta is unchanged, and the state stays IDLE.
  - 001: operation with cuenta<2.
  - 010: number while full (cuenta==2**ANCHO_DIR-1).
  - 011: opcode outside A..E (including F).
  - codigo_error_o holds its value until the next successful transfer, which clears it to 000.
- ALU outputs are zero in IDLE. RF addresses are 0 outside LEER_OPS and the write states.
- No wrap-around of cuenta ever occurs.

Optional Feature:
- Macro: SECUENCIADOR_DIVCERO_EN.
- Defined: in ESCRIBIR_RES, if alu_op_o is D or E and alu_b_o==0, the block suppresses rf_we_o and resultado_valid_o, sets codigo_error_o=100, and leaves cuenta unchanged.
- Undefined: the result is written unconditionally, whatever the ALU returns.

Decomposition:
- Package secuenciador_pkg: state enum type, opcode constants (OP_SUMA..OP_MOD), error code constants (ERR_NINGUNO, ERR_FALTA_OPERANDO, ERR_PILA_LLENA, ERR_OPCODE, ERR_DIVCERO).
- The design is a single module; the LAT_ALU wait counter stays inline, and no sub-module is needed.

Test Plan:
- Reset then push 5, push 7 → rf_we_o pulses at addr 1 data 5 and at addr 2 data 7; cuenta_o=2.
- Depth 2 (5,7), op B → raddr 1/2 in LEER_OPS; write at addr 1 of alu_res_pi (model: 0xFFFE) at acceptance+LAT_ALU+2 cycles; resultado_valid_o pulses once; cuenta_o=1.
- op_valid_pi and num_valid_pi both high in IDLE → only the op is accepted; num_ready_o=0 that cycle; the number is accepted the next IDLE cycle.
- Op with cuenta=1 → codigo_error_o=001, no rf_we_o; then push 3 → error clears to 000.
- Push 31 numbers, then a 32nd → error 010 with cuenta_o=31; opcode F at depth 2 → error 011.
- reset_pi asserted asynchronously mid-ESPERAR_ALU → outputs are 0 immediately, no write occurs, cuenta_o=0; with SECUENCIADOR_DIVCERO_EN, 8 then 0 followed by op D → error 100, no write.
